// File: rtl/tt_seq_mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
// Signed support is compiled in with TT_SEQ_MULT_SIGNED_EN.
package tt_seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/tt_seq_mult_dp.sv
// Multiplier datapath: accumulator, operand shifters and iteration counter.
// Signed support is compiled in with TT_SEQ_MULT_SIGNED_EN.
module tt_seq_mult_dp
    import tt_seq_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               step_i,
`ifdef TT_SEQ_MULT_SIGNED_EN
    input  logic               signed_i,
`endif
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               last_o,
    output logic [2*WIDTH-1:0] product_o
);

    localparam int CW = cnt_width(WIDTH);
    localparam int PW = 2 * WIDTH;

    logic [PW-1:0]    acc_q, mcand_q, prod_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CW-1:0]    cnt_q;
    logic [PW-1:0]    sum, res;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             neg;

`ifdef TT_SEQ_MULT_SIGNED_EN
    logic neg_q, neg_d;

    // Multiply magnitudes; the sign is reapplied when the result is stored.
    always_comb begin
        a_mag = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
        b_mag = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
        neg_d = signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_q <= 1'b0;
        end else if (load_i) begin
            neg_q <= neg_d;
        end
    end

    assign neg = neg_q;
`else
    assign a_mag = a_i;
    assign b_mag = b_i;
    assign neg   = 1'b0;
`endif

    always_comb begin
        sum    = acc_q + (mplier_q[0] ? mcand_q : '0);
        res    = neg ? -sum : sum;
        last_o = step_i && (cnt_q == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            prod_q   <= '0;
        end else if (load_i) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a_mag};
            mplier_q <= b_mag;
            cnt_q    <= '0;
        end else if (step_i) begin
            acc_q    <= sum;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            if (last_o) begin
                prod_q <= res;
            end
        end
    end

    assign product_o = prod_q;

endmodule

// File: rtl/tt_um_seq_mult.sv
// Sequential multiplier top: IDLE/RUN/DONE control and valid/ready handshake.
// Signed support is compiled in with TT_SEQ_MULT_SIGNED_EN.
module tt_um_seq_mult
    import tt_seq_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
`ifdef TT_SEQ_MULT_SIGNED_EN
    input  logic               is_signed,
`endif
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("tt_um_seq_mult: WIDTH out of range");
    end

    state_t state_q, state_d;
    logic   load, step, last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign busy      = (state_q == RUN);
    assign out_valid = (state_q == DONE);

    tt_seq_mult_dp #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk      (clk),
        .rst      (rst),
        .load_i   (load),
        .step_i   (step),
`ifdef TT_SEQ_MULT_SIGNED_EN
        .signed_i (is_signed),
`endif
        .a_i      (a),
        .b_i      (b),
        .last_o   (last),
        .product_o(product)
    );

endmodule

// File: tb/tb_tt_um_seq_mult.sv
// Randomized self-checking bench for tt_um_seq_mult against an arithmetic model.
// Signed cases are included when TT_SEQ_MULT_SIGNED_EN is defined.
module tb_tt_um_seq_mult;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready, is_s;
    logic [7:0]  a, b;
    logic        in_ready, out_valid, busy;
    logic [15:0] product;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [2:0]  sw_go = '0;
    logic [2:0]  sw_done = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tt_um_seq_mult #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef TT_SEQ_MULT_SIGNED_EN
        .is_signed(is_s),
`endif
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .product  (product),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [7:0] x,
                                          input logic [7:0] y,
                                          input logic s);
        logic signed [15:0] sx, sy;
        if (s) begin
            sx = {{8{x[7]}}, x};
            sy = {{8{y[7]}}, y};
            return 16'(sx * sy);
        end
        return {8'h0, x} * {8'h0, y};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_,
                         input logic ts, input int hold, input string tag);
        logic [15:0] exp;
        int n, bc;
        exp = model(ta, tb_, ts);
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, in_ready, 1);
        a = ta;
        b = tb_;
        is_s = ts;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        n = 0;
        bc = 0;
        while (!out_valid && n < 100) begin
            if (busy) bc++;
            tick();
            n++;
        end
        check({tag, "_latency"}, n, 8);
        check({tag, "_busy"}, bc, 8);
        check({tag, "_product"}, product, exp);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            tick();
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_prod"}, product, exp);
            check({tag, "_hold_ready"}, in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_idle_valid"}, out_valid, 0);
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_prod"}, product, exp);
    endtask

    localparam int SWW [3] = '{8, 2, 16};

    for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
        localparam int GW = SWW[gi];
        logic            gv, grdy, gov, gbusy;
        logic [GW-1:0]   ga, gb;
        logic [2*GW-1:0] gp;

        tt_um_seq_mult #(.WIDTH(GW)) u_dut (
            .clk      (clk),
            .rst      (rst),
`ifdef TT_SEQ_MULT_SIGNED_EN
            .is_signed(1'b0),
`endif
            .in_valid (gv),
            .in_ready (grdy),
            .a        (ga),
            .b        (gb),
            .out_valid(gov),
            .out_ready(1'b1),
            .product  (gp),
            .busy     (gbusy)
        );

        initial begin
            logic [2*GW-1:0] e;
            int prev, n;
            gv = 1'b0;
            ga = '0;
            gb = '0;
            prev = 0;
            wait (sw_go[gi]);
            tick();
            gv = 1'b1;
            for (int op = 0; op < 6; op++) begin
                ga = GW'($urandom);
                gb = GW'($urandom);
                e = {{GW{1'b0}}, ga} * {{GW{1'b0}}, gb};
                n = 0;
                while (!grdy && n < 50) begin
                    tick();
                    n++;
                end
                tick();
                if (op > 0) check($sformatf("sweep%0d_gap", GW), cyc - prev - 1, GW + 1);
                prev = cyc;
                n = 0;
                while (!gov && n < 100) begin
                    tick();
                    n++;
                end
                check($sformatf("sweep%0d_lat", GW), n, GW);
                check($sformatf("sweep%0d_prod", GW), gp, e);
            end
            gv = 1'b0;
            sw_done[gi] = 1'b1;
        end
    end

    initial begin
        int n, ov;
        logic [7:0] ra, rb;
        logic rs;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        is_s = 1'b0;
        a = '0;
        b = '0;
        repeat (3) tick();
        check("rst_ready", in_ready, 0);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_prod", product, 0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", in_ready, 1);

        do_op(8'd13, 8'd11, 1'b0, 0, "13x11");
        do_op(8'd255, 8'd255, 1'b0, 0, "255x255");
        do_op(8'd0, 8'd200, 1'b0, 0, "0x200");
        do_op(8'd21, 8'd6, 1'b0, 5, "hold5");
        do_op(8'hFD, 8'd5, 1'b0, 1, "u_fdx5");
`ifdef TT_SEQ_MULT_SIGNED_EN
        do_op(8'hFD, 8'd5, 1'b1, 0, "s_m3x5");
        do_op(8'h80, 8'h80, 1'b1, 0, "s_m128sq");
`endif

        // Abort during iteration 4 of a run.
        a = 8'hAB;
        b = 8'hCD;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        check("abort_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_prod", product, 0);
        check("abort_ready", in_ready, 0);
        tick();
        rst = 1'b0;
        #1;
        check("abort_rel_ready", in_ready, 1);
        ov = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) ov++;
        end
        check("abort_no_valid", ov, 0);
        do_op(8'd7, 8'd9, 1'b0, 0, "7x9");

        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
`ifdef TT_SEQ_MULT_SIGNED_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            do_op(ra, rb, rs, int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
        end

        for (int g = 0; g < 3; g++) begin
            sw_go[g] = 1'b1;
            n = 0;
            while (!sw_done[g] && n < 2000) begin
                tick();
                n++;
            end
            check($sformatf("sweep_finish%0d", g), sw_done[g], 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
